// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle restoring radix-2 divide/remainder unit for DIV, DIVU, REM and REMU
module iter_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    logic [1:0]      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_signed;
    logic            is_rem;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            q_bit;
    logic [XLEN:0]   rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] rem_low;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            sgn_ovf;

    always_comb begin
        is_signed   = ~op_q[0];
        is_rem      = op_q[1];
        // a_q doubles as the quotient shift register once magnitudes are loaded
        rem_shift   = {rem_q[XLEN-1:0], a_q[XLEN-1]};
        trial       = rem_shift - {1'b0, b_q};
        q_bit       = ~trial[XLEN];
        rem_next    = q_bit ? trial : rem_shift;
        quo_next    = {a_q[XLEN-2:0], q_bit};
        rem_low     = rem_next[XLEN-1:0];
        quo_fix     = negq_q ? -quo_next : quo_next;
        rem_fix     = negr_q ? -rem_low : rem_low;
        a_mag       = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
        b_mag       = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
        div_by_zero = (b_q == '0);
        sgn_ovf     = is_signed && (a_q == MIN_NEG) && (b_q == ALL_ONES);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    state_d = S_CALC;
                    op_d    = op;
                    a_d     = dividend;
                    b_d     = divisor;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    // First CALC cycle: resolve early exits or load magnitudes and signs
                    if (div_by_zero) begin
                        result_d = is_rem ? a_q : ALL_ONES;
                        state_d  = S_DONE;
                    end else if (sgn_ovf) begin
                        result_d = is_rem ? '0 : a_q;
                        state_d  = S_DONE;
                    end else begin
                        a_d    = a_mag;
                        b_d    = b_mag;
                        rem_d  = '0;
                        negq_d = is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                        negr_d = is_signed & a_q[XLEN-1];
                        cnt_d  = CNT_ONE;
                    end
                end else begin
                    a_d   = quo_next;
                    rem_d = rem_next;
                    if (cnt_q == CNT_LAST) begin
                        result_d = is_rem ? rem_fix : quo_fix;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule
